// File: rtl/slib_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slib_edge_pkg
// Purpose  : Shared definitions for the slib edge filter.
//            - MODE field encoding (one 2-bit field per channel)
//            - helpers to pull a channel's field out of the packed MODE
//              vector and to decode which edges it selects
// Revision : 1.0 - initial release
// ============================================================================
package slib_edge_pkg;

  // Per-channel event select encoding
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Largest channel count the mode helper can address. The top pads its
  // MODE vector up to this width before calling edge_mode().
  localparam int MAX_CH = 64;

  // Return the 2-bit mode field of channel ch.
  function automatic logic [1:0] edge_mode(input logic [2*MAX_CH-1:0] mode_vec,
                                           input int                  ch);
    return mode_vec[2*ch +: 2];
  endfunction

  // True when the field selects rising edges.
  function automatic logic sel_rise(input logic [1:0] m);
    return (m == EDGE_RISE) || (m == EDGE_BOTH);
  endfunction

  // True when the field selects falling edges.
  function automatic logic sel_fall(input logic [1:0] m);
    return (m == EDGE_FALL) || (m == EDGE_BOTH);
  endfunction

endpackage : slib_edge_pkg
`default_nettype wire

// File: rtl/slib_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : slib_input_filter
// Purpose  : One channel of the edge filter: synchroniser chain, stability
//            counter, filtered level and registered edge pulses.
// Ports    : CLK      - clock, rising edge
//            RSTn     - asynchronous active-low reset
//            EN       - filter/detect enable (synchroniser always runs)
//            D        - raw asynchronous input
//            FILT_LEN - extra stable cycles needed before a level is taken
//            Q        - filtered level
//            RE / FE  - one-cycle rising / falling pulse, registered
// Revision : 1.0 - initial release
// ============================================================================
module slib_input_filter #(
  parameter int   SYNC_STAGES = 2,     // must be >= 2
  parameter int   FILT_BITS   = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 EN,
  input  logic                 D,
  input  logic [FILT_BITS-1:0] FILT_LEN,
  output logic                 Q,
  output logic                 RE,
  output logic                 FE
);

  localparam logic [FILT_BITS-1:0] C_CNT_MAX = {FILT_BITS{1'b1}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILT_BITS-1:0]   r_cnt;
  logic                   r_q;
  logic                   r_re;
  logic                   r_fe;

  logic                   w_s;
  logic [FILT_BITS-1:0]   w_cnt_nxt;
  logic                   w_q_nxt;
  logic                   w_re_nxt;
  logic                   w_fe_nxt;

  // --------------------------------------------------------------------------
  // Synchroniser: free-running, independent of EN, so that enabling the
  // filter sees an already-settled level.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], D};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Stability filter. The counter measures how long S has disagreed with Q;
  // once it reaches FILT_LEN the next disagreeing cycle commits the level.
  // FILT_LEN is compared live, so lowering it can commit a pending level
  // immediately (cnt >= FILT_LEN).
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_nxt = '0;
    w_q_nxt   = r_q;
    w_re_nxt  = 1'b0;
    w_fe_nxt  = 1'b0;
    if (EN && (w_s != r_q)) begin
      if (r_cnt >= FILT_LEN) begin
        w_q_nxt  = w_s;
        w_re_nxt = w_s;
        w_fe_nxt = ~w_s;
      end else if (r_cnt != C_CNT_MAX) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
      r_q   <= RESET_LEVEL;
      r_re  <= 1'b0;
      r_fe  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_q   <= w_q_nxt;
      r_re  <= w_re_nxt;
      r_fe  <= w_fe_nxt;
    end
  end

  assign Q  = r_q;
  assign RE = r_re;
  assign FE = r_fe;

endmodule : slib_input_filter
`default_nettype wire

// File: rtl/slib_edge_filter.sv
`default_nettype none
// ============================================================================
// Module   : slib_edge_filter
// Purpose  : Multi-channel glitch-filtered edge detector with sticky,
//            mode-selected event flags and a combined interrupt.
// Ports    : CLK      - clock, rising edge
//            RSTn     - asynchronous active-low reset
//            EN       - filter/detect enable
//            D        - raw asynchronous inputs, one per channel
//            FILT_LEN - shared filter length
//            MODE     - 2 bits per channel: 00 off, 01 rise, 10 fall, 11 both
//            CLR      - write-1-to-clear for EVT
//            Q        - filtered levels
//            RE / FE  - registered one-cycle edge pulses
//            EVT      - sticky event flags
//            IRQ      - OR of EVT
// Revision : 1.0 - initial release
// ============================================================================
module slib_edge_filter
  import slib_edge_pkg::*;
#(
  parameter int   WIDTH       = 8,     // 1..MAX_CH
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_BITS   = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 EN,
  input  logic [WIDTH-1:0]     D,
  input  logic [FILT_BITS-1:0] FILT_LEN,
  input  logic [2*WIDTH-1:0]   MODE,
  input  logic [WIDTH-1:0]     CLR,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     RE,
  output logic [WIDTH-1:0]     FE,
  output logic [WIDTH-1:0]     EVT,
  output logic                 IRQ
);

  logic [WIDTH-1:0]      w_re;
  logic [WIDTH-1:0]      w_fe;
  logic [WIDTH-1:0]      w_set;
  logic [2*MAX_CH-1:0]   w_mode_ext;
  logic [WIDTH-1:0]      r_evt;

  // --------------------------------------------------------------------------
  // Per-channel filters
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      slib_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_BITS   (FILT_BITS),
        .RESET_LEVEL (RESET_LEVEL)
      ) u_filt (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .EN       (EN),
        .D        (D[gi]),
        .FILT_LEN (FILT_LEN),
        .Q        (Q[gi]),
        .RE       (w_re[gi]),
        .FE       (w_fe[gi])
      );
    end
  endgenerate

  assign RE = w_re;
  assign FE = w_fe;

  // --------------------------------------------------------------------------
  // Event flags. Pulses come straight from registers, so the flag sets one
  // cycle after the pulse. A same-cycle set beats a clear so no event that
  // arrives while software is acknowledging an older one is lost.
  // --------------------------------------------------------------------------
  always_comb begin
    w_mode_ext            = '0;
    w_mode_ext[2*WIDTH-1:0] = MODE;
  end

  always_comb begin
    w_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_set[i] = (w_re[i] & sel_rise(edge_mode(w_mode_ext, i))) |
                 (w_fe[i] & sel_fall(edge_mode(w_mode_ext, i)));
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_evt <= '0;
    end else begin
      r_evt <= w_set | (r_evt & ~CLR);
    end
  end

  assign EVT = r_evt;

  // Reduction of registered flags only, so IRQ cannot glitch on D/MODE/CLR.
  assign IRQ = |r_evt;

endmodule : slib_edge_filter
`default_nettype wire

// File: doc/slib_edge_filter.md
# slib_edge_filter

Multi-channel, parametrised edge detector for the slib peripheral library. Each channel synchronises an asynchronous input, rejects glitches with a programmable stability filter, and emits one-cycle rise and fall pulses. It also holds per-channel sticky event flags, selected by an edge mode, that combine into a single interrupt. It sits between raw pins (UART modem lines, GPIO, external strobes) and the register/interrupt logic of a peripheral, replacing single-bit combinational edge detection.

## Interface
- WIDTH, 8: number of channels.
- SYNC_STAGES, 2: synchroniser flops per channel; minimum 2.
- FILT_BITS, 4: width of the filter length and filter counter.
- RESET_LEVEL, 1'b0: reset value of every synchroniser flop and of Q.

- CLK  in  1  clock; all logic on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- EN  in  1  filter/detect enable.
- D  in  WIDTH  raw asynchronous inputs.
- FILT_LEN  in  FILT_BITS  extra stable cycles required before a level is accepted; shared by all channels.
- MODE  in  2*WIDTH  per-channel event select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- CLR  in  WIDTH  write-1-to-clear for EVT.
- Q  out  WIDTH  filtered level.
- RE  out  WIDTH  one-cycle rising-edge pulse, registered.
- FE  out  WIDTH  one-cycle falling-edge pulse, registered.
- EVT  out  WIDTH  sticky event flags.
- IRQ  out  1  OR of EVT.

## Operation
- Synchroniser: a SYNC_STAGES flop chain per channel. It runs regardless of EN. S is the last stage.
- Filter, per channel, with a saturating counter cnt[FILT_BITS]:
  - When EN=0: cnt is held at 0, Q holds, RE and FE are 0.
  - When S==Q: cnt is set to 0.
  - When S!=Q and cnt<FILT_LEN: cnt increments, saturating at all-ones with no wrap.
  - When S!=Q and cnt>=FILT_LEN: Q is loaded with S, cnt is set to 0, and RE (if S=1) or FE (if S=0) is set for that single cycle.
- A level must therefore differ from Q at S for FILT_LEN+1 consecutive cycles. Shorter pulses are discarded silently.
- FILT_LEN changes take effect on the next compare; no restart is needed.
- RE and FE are never both high on a channel. Both are 0 in every cycle where Q does not change.
- EVT[i] is set the cycle after a pulse that MODE[i] selects: (RE & MODE[2i]) | (FE & MODE[2i+1]). Otherwise CLR[i]=1 clears EVT[i].
  - Set and clear in the same cycle: set wins.
  - Changing MODE never clears existing flags.
- IRQ = |EVT, combinational from the EVT registers and glitch-free.
- Reset state: sync flops = RESET_LEVEL, Q = {WIDTH{RESET_LEVEL}}, cnt = 0, RE = FE = EVT = 0, IRQ = 0.
  - Reset mid-count abandons the count with no pulse.
  - After release, an input that differs from RESET_LEVEL is detected as a normal edge.

## Timing
- Edge k is the k-th rising CLK edge after D changes.
- S reflects D at edge SYNC_STAGES.
- Q and RE/FE update at edge SYNC_STAGES+1+FILT_LEN.
- EVT updates at edge SYNC_STAGES+2+FILT_LEN; IRQ follows EVT in the same cycle.
- Minimum accepted pulse width at S: FILT_LEN+1 cycles.
- Maximum event rate per channel: one edge every FILT_LEN+1 cycles.
- No combinational path from D, MODE, or CLR to any output.

## Structure
- Package slib_edge_pkg holds:
  - the MODE encoding constants EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH;
  - the helper that extracts a 2-bit mode from the MODE vector.
- Sub-module slib_input_filter is one channel: synchroniser, counter, Q, RE and FE. Parameters: SYNC_STAGES, FILT_BITS, RESET_LEVEL.
- Top-level responsibilities: a generate loop of WIDTH slib_input_filter instances, the EVT/CLR logic, and the IRQ OR-reduction.

## Test plan
- Reset: hold RSTn=0 with D=8'hFF. Required: Q=8'h00, RE=FE=EVT=0, IRQ=0. Release with D still 8'hFF, FILT_LEN=0, MODE=all 01: RE=8'hFF for exactly one cycle at edge 3, EVT=8'hFF and IRQ=1 at edge 4.
- Filter: FILT_LEN=3, D[0] high for 3 cycles → no Q, RE, or EVT change. High for 4 cycles → Q[0]=1 and RE[0] pulse at edge 6.
- Modes: toggle D[3:0] 0→1→0 with MODE[7:0]=8'b11_10_01_00. Required: EVT[0]=0, EVT[1] set on rise only, EVT[2] set on fall only, EVT[3] set on both. RE and FE pulse on all four channels regardless of mode.
- Clear race: CLR[5]=1 in the same cycle a selected event sets EVT[5] → EVT[5] stays 1. CLR[5]=1 alone next cycle → EVT[5]=0 and IRQ=0.
- Enable: EN=0 while D toggles → Q frozen, no RE/FE/EVT. EN=1 → pending level accepted after FILT_LEN+1 cycles.
- Saturation and reset mid-count: FILT_BITS=4, FILT_LEN=15, D held high for 20 cycles → exactly one RE. Assert RSTn=0 at count 10 of a later edge → no pulse, all outputs at reset values.
